// File: rtl/wait_state_memory.sv
// Unified word memory with req/done handshake, programmable wait states, sub-word access and range checking.
// Optional feature: define MEM_MISALIGN_TRAP_EN to flag misaligned half/word accesses as errors.
module wait_state_memory #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [31:0]       mem_q [DEPTH];

  logic [IDX_W-1:0]  idx_c;
  logic              in_range_c, misalign_c, bad_c, commit_c;
  logic [31:0]       old_c, merged_c, load_c;
  logic [4:0]        bsh_c, hsh_c;
  logic [7:0]        byte_c;
  logic [15:0]       half_c;

  // Address decode, lane steering and load extension for the latched request.
  always_comb begin
    idx_c      = addr_q[IDX_W+1:2];
    in_range_c = (addr_q[31:2] < 30'(DEPTH));
`ifdef MEM_MISALIGN_TRAP_EN
    misalign_c = (size_q == 2'b01) ? addr_q[0] : (size_q[1] && (addr_q[1:0] != 2'b00));
`else
    misalign_c = 1'b0;
`endif
    bad_c    = !in_range_c || misalign_c;
    old_c    = in_range_c ? mem_q[idx_c] : 32'h0;
    bsh_c    = {addr_q[1:0], 3'b000};
    hsh_c    = {addr_q[1], 4'b0000};
    byte_c   = old_c[bsh_c +: 8];
    half_c   = old_c[hsh_c +: 16];
    merged_c = old_c;
    load_c   = old_c;
    case (size_q)
      2'b00: begin
        merged_c[bsh_c +: 8] = wdata_q[7:0];
        load_c = {{24{byte_c[7] & ~uns_q}}, byte_c};
      end
      2'b01: begin
        merged_c[hsh_c +: 16] = wdata_q[15:0];
        load_c = {{16{half_c[15] & ~uns_q}}, half_c};
      end
      default: begin
        merged_c = wdata_q;
        load_c   = old_c;
      end
    endcase
  end

  // Handshake FSM: accept in IDLE, count wait states, complete in DONE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    size_d   = size_q;
    uns_d    = uns_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    done_d   = 1'b0;
    err_d    = err_q;
    rdata_d  = rdata_q;
    commit_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          we_d    = we_i;
          size_d  = size_i;
          uns_d   = uns_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d  = ST_DONE;
          done_d   = 1'b1;
          err_d    = bad_c;
          commit_c = we_q && !bad_c;
          if (!we_q) begin
            rdata_d = bad_c ? 32'h0 : load_c;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Array has no reset; a reset on the commit edge drops the in-flight store.
  always_ff @(posedge clk_i) begin
    if (rst_i && commit_c) begin
      mem_q[idx_c] <= merged_c;
    end
  end

  assign ready_o = ready_q;
  assign done_o  = done_q;
  assign rdata_o = rdata_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_wait_state_memory.sv
// Randomized bench for wait_state_memory against a word-array reference model with cycle-exact handshake timing.
module tb_wait_state_memory;

  localparam int unsigned DEPTH = 1024;
  localparam int          W     = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        uns = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        ready_o, done_o, err_o;
  logic [31:0] rdata_o;

  wait_state_memory #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .size_i(size), .uns_i(uns),
    .addr_i(addr), .wdata_i(wdata), .ready_o(ready_o), .done_o(done_o),
    .rdata_o(rdata_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int          chk_cnt = 0;
  int          err_cnt = 0;
  int          pc = 0;
  int          acc_cyc = -1;
  bit          chk_en = 1'b0;
  logic [31:0] model_mem [32];
  logic [31:0] held_rdata = 32'h0;
  logic        pend_we, pend_err;
  logic [31:0] pend_rdata, pend_word;
  logic [4:0]  pend_idx;
  logic [31:0] cap_rdata;
  logic        cap_err;

  always @(posedge clk) pc <= pc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, pc);
    end
  endtask

  function automatic bit model_busy();
    return (acc_cyc >= 0) && (pc >= acc_cyc) && (pc <= acc_cyc + W + 1);
  endfunction

  // Reference: result of one access against the current model array.
  task automatic model_op(input logic w, input logic [1:0] s, input logic u,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic e, output logic [31:0] nw);
    logic [31:0] widx, old, mask, val, f;
    int sh;
    bit mis;
    widx = a >> 2;
    mis  = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    if (s == 2'd1 && a[0]) mis = 1'b1;
    if (s >= 2'd2 && a[1:0] != 2'd0) mis = 1'b1;
`endif
    e   = (widx >= 32'(DEPTH)) || mis;
    old = (widx < 32'(DEPTH)) ? model_mem[a[6:2]] : 32'h0;
    if (s == 2'd0) begin
      sh   = 8 * int'(a[1:0]);
      mask = 32'hFF << sh;
      f    = (old >> sh) & 32'hFF;
      rd   = (!u && f >= 32'h80) ? (f | 32'hFFFFFF00) : f;
    end else if (s == 2'd1) begin
      sh   = a[1] ? 16 : 0;
      mask = 32'hFFFF << sh;
      f    = (old >> sh) & 32'hFFFF;
      rd   = (!u && f >= 32'h8000) ? (f | 32'hFFFF0000) : f;
    end else begin
      sh   = 0;
      mask = 32'hFFFFFFFF;
      rd   = old;
    end
    val = d << sh;
    nw  = (old & ~mask) | (val & mask);
    if (e) rd = 32'h0;
  endtask

  // Per-cycle comparison of every output against the model's timing and data.
  always @(negedge clk) begin
    bit exp_done;
    if (chk_en) begin
      exp_done = (acc_cyc >= 0) && (pc == acc_cyc + W + 1);
      if (exp_done) begin
        if (pend_we && !pend_err) model_mem[pend_idx] = pend_word;
        if (!pend_we) held_rdata = pend_rdata;
      end
      check("ready", 32'(ready_o), 32'(!model_busy()));
      check("done", 32'(done_o), 32'(exp_done));
      check("rdata", rdata_o, held_rdata);
      if (exp_done) check("err", 32'(err_o), 32'(pend_err));
    end
    if (done_o) begin
      cap_rdata = rdata_o;
      cap_err   = err_o;
    end
  end

  task automatic access(input logic w, input logic [1:0] s, input logic u,
                        input logic [31:0] a, input logic [31:0] d, input bit poke);
    logic [31:0] rd, nw;
    logic e;
    int k;
    @(negedge clk);
    k = 0;
    while (model_busy() && k < 64) begin @(negedge clk); k++; end
    model_op(w, s, u, a, d, rd, e, nw);
    pend_we = w; pend_err = e; pend_rdata = rd; pend_word = nw; pend_idx = a[6:2];
    cap_rdata = 32'hxxxxxxxx; cap_err = 1'bx;
    req = 1'b1; we = w; size = s; uns = u; addr = a; wdata = d;
    acc_cyc = pc + 1;
    @(negedge clk);
    req = 1'b0; we = 1'($urandom); size = 2'($urandom); uns = 1'($urandom);
    addr = $urandom; wdata = $urandom;
    if (poke) begin
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
    end
    k = 0;
    while (pc < acc_cyc + W + 2 && k < 64) begin @(negedge clk); k++; end
    if (k >= 64) check("access_timeout", 32'(k), 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int r;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_rdata", rdata_o, 32'h0);
    check("rst_err", 32'(err_o), 32'd0);
    rst = 1'b1;
    held_rdata = 32'h0;
    chk_en = 1'b1;

    for (int i = 0; i < 32; i++) access(1'b1, 2'd2, 1'b0, 32'(i * 4), 32'hA5000000 | 32'(i), 1'b0);

    access(1'b1, 2'd2, 1'b0, 32'h10, 32'h12345678, 1'b0);
    access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0);
    check("word_load_0x10", cap_rdata, 32'h12345678);

    access(1'b1, 2'd0, 1'b0, 32'h13, 32'h00000080, 1'b0);
    access(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 1'b0);
    check("byte_load_signed", cap_rdata, 32'hFFFFFF80);
    access(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 1'b0);
    check("byte_load_unsigned", cap_rdata, 32'h00000080);
    access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0);
    check("word_after_byte", cap_rdata, 32'h80345678);

    access(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000BEEF, 1'b0);
    access(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 1'b0);
    check("half_load_signed", cap_rdata, 32'hFFFFBEEF);
    access(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 1'b0);
    check("half_load_unsigned", cap_rdata, 32'h0000BEEF);
    access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0);
    check("word_after_half", cap_rdata, 32'hBEEF5678);

    access(1'b1, 2'd2, 1'b0, 32'h1000, 32'h1, 1'b0);
    check("oor_store_err", 32'(cap_err), 32'd1);
    access(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 1'b0);
    check("word0_unchanged", cap_rdata, 32'hA5000000);
    access(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 1'b0);
    check("oor_load_rdata", cap_rdata, 32'h0);
    check("oor_load_err", 32'(cap_err), 32'd1);

    access(1'b1, 2'd2, 1'b0, 32'h21, 32'hCAFEF00D, 1'b1);
    access(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0);
`ifdef MEM_MISALIGN_TRAP_EN
    check("misaligned_word8", cap_rdata, 32'hA5000008);
`else
    check("unaligned_word8", cap_rdata, 32'hCAFEF00D);
`endif

    // Reset in the middle of a store's wait states.
    chk_en = 1'b0;
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'd2; uns = 1'b0; addr = 32'h40; wdata = 32'hDEADBEEF;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    check("midwait_rst_ready", 32'(ready_o), 32'd1);
    check("midwait_rst_done", 32'(done_o), 32'd0);
    check("midwait_rst_rdata", rdata_o, 32'h0);
    acc_cyc = -1;
    held_rdata = 32'h0;
    chk_en = 1'b1;
    access(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 1'b0);
    check("aborted_store_0x40", cap_rdata, 32'hA5000010);

    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      if (r < 8) a = 32'($urandom_range(0, 127));
      else if (r == 8) a = 32'((DEPTH + $urandom_range(0, 3)) * 4 + $urandom_range(0, 3));
      else a = $urandom | 32'h80000000;
      access(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, 1'($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule
